// File: rtl/i2c_reg_target.sv
// I2C register-bank target: oversampled SCL/SDA, auto-incrementing pointer, open-drain pull-low intents.
// Optional clock stretching after each ACK slot is enabled by defining CLK_STRETCH_EN.
module i2c_reg_target #(
  parameter logic [6:0] TGT_ADDR    = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         PTR_W       = 4
`ifdef CLK_STRETCH_EN
  ,
  parameter int         STRETCH_CYC = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_low_o,
  output logic             scl_low_o,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_stb_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_IGNORE, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_e;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [1:0]       scl_sync_q, sda_sync_q;
  logic             scl_prev_q, sda_prev_q;
  logic             scl_s, sda_s;
  logic             scl_rise, scl_fall, start_det, stop_det;
  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_low_q, sda_low_d;
  logic             busy_q, busy_d;
  logic             wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       regs_q [NUM_REGS];

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // The write commits on the 8th rise so a START/STOP before it discards the byte.
            if (state_q == S_WR_DATA && bit_cnt_q == 4'd7) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = {shift_q[6:0], sda_s};
              ptr_d     = ptr_q + PTR_ONE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_low_d = 1'b1;
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == TGT_ADDR) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d   = S_IGNORE;
                sda_low_d = 1'b0;
                busy_d    = 1'b0;
              end
            end else if (state_q == S_PTR) begin
              state_d = S_PTR_ACK;
              ptr_d   = shift_q[PTR_W-1:0];
            end else begin
              state_d = S_WR_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d   = S_RD_DATA;
              shift_d   = regs_q[ptr_q];
              sda_low_d = ~regs_q[ptr_q][7];
            end else begin
              state_d   = S_PTR;
              sda_low_d = 1'b0;
            end
          end
        end
        S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            state_d   = S_WR_DATA;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = S_RD_ACK;
              sda_low_d = 1'b0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
            end
          end
        end
        S_RD_ACK: begin
          // shift_q[0] keeps the master's ACK bit until the slot ends.
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            ptr_d   = ptr_q + PTR_ONE;
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (!shift_q[0]) begin
              state_d   = S_RD_DATA;
              shift_d   = regs_q[ptr_q];
              sda_low_d = ~regs_q[ptr_q][7];
            end else begin
              state_d = S_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (wr_stb_d) regs_q[wr_addr_d] <= wr_data_d;
    end
  end

`ifdef CLK_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYC + 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYC);
  localparam logic [SW-1:0] STRETCH_ONE  = SW'(1);

  logic          ack_fall;
  logic [SW-1:0] stretch_q;

  // Holding SCL low keeps the FSM parked: it only moves on after synced SCL rises again.
  assign ack_fall = scl_fall & ~start_det & ~stop_det &
                    ((state_q == S_ADDR_ACK) | (state_q == S_PTR_ACK) |
                     (state_q == S_WR_ACK)   | (state_q == S_RD_ACK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 stretch_q <= '0;
    else if (ack_fall)       stretch_q <= STRETCH_LOAD;
    else if (stretch_q != 0) stretch_q <= stretch_q - STRETCH_ONE;
  end

  assign scl_low_o = (stretch_q != '0);
`else
  assign scl_low_o = 1'b0;
`endif

  assign sda_low_o  = sda_low_q;
  assign busy_o     = busy_q;
  assign wr_stb_o   = wr_stb_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-level I2C master on a wired-AND bus, register/pointer model,
// per-cycle compare process. Define CLK_STRETCH_EN to also cover the stretching build.
module tb_i2c_reg_target;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_low_o, scl_low_o, wr_stb_o, busy_o;
  logic [3:0] host_addr = 4'd0;
  logic [3:0] wr_addr_o;
  logic [7:0] host_rdata, wr_data_o;

  assign scl_in = scl_m & ~scl_low_o;
  assign sda_in = sda_m & ~sda_low_o;

  i2c_reg_target dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .sda_low_o(sda_low_o), .scl_low_o(scl_low_o),
    .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model [16];
  int         ptrM = 0;
  logic       holdHost = 1'b1;
  wr_t        expQ [$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random host read-back index, so the compare process sweeps the whole bank.
  always begin
    @(posedge clk);
    #1;
    if (!holdHost) host_addr = 4'($urandom_range(0, 15));
  end

  // Compare process: write strobes against the scoreboard, read-back port against the model,
  // SDA stability while SCL is high, and the SCL stretch output.
  logic prevScl = 1'b1, prevSdaLow = 1'b0, prevRst = 1'b1;
  int   stretchRun = 0;
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      stretchRun = 0;
    end else begin
      if (wr_stb_o) begin
        if (expQ.size() == 0) checkOutput("unexpected_wr_stb", 1, 0);
        else begin
          e = expQ.pop_front();
          checkOutput("wr_addr", wr_addr_o, e.a);
          checkOutput("wr_data", wr_data_o, e.d);
          model[e.a] = e.d;
        end
      end
      checkOutput("host_rdata", host_rdata, model[host_addr]);
      if (!prevRst && prevScl && scl_in) checkOutput("sda_stable_scl_high", sda_low_o, prevSdaLow);
`ifdef CLK_STRETCH_EN
      if (scl_low_o) stretchRun++;
      else if (stretchRun != 0) begin
        checkOutput("stretch_len", stretchRun, 8);
        stretchRun = 0;
      end
`else
      checkOutput("scl_low_idle", scl_low_o, 0);
`endif
    end
    prevScl    = scl_in;
    prevSdaLow = sda_low_o;
    prevRst    = rst;
  end

  task automatic sclHigh();
    int t = 0;
    scl_m = 1'b1;
    while (!scl_in && t < 200) begin
      waitClk(1);
      t++;
    end
    if (!scl_in) checkOutput("scl_release_timeout", 0, 1);
  endtask

  task automatic sendBit(input logic b);
    waitClk(Q); sda_m = b; waitClk(Q); sclHigh(); waitClk(2 * Q); scl_m = 1'b0;
  endtask

  task automatic recvBit(output logic b);
    waitClk(Q); sda_m = 1'b1; waitClk(Q); sclHigh(); waitClk(Q); b = sda_in; waitClk(Q); scl_m = 1'b0;
  endtask

  task automatic startCond();
    waitClk(Q); sda_m = 1'b1; waitClk(Q); sclHigh(); waitClk(Q); sda_m = 1'b0; waitClk(Q); scl_m = 1'b0;
  endtask

  task automatic stopCond();
    waitClk(Q); sda_m = 1'b0; waitClk(Q); sclHigh(); waitClk(Q); sda_m = 1'b1; waitClk(2 * Q);
  endtask

  task automatic writeByte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(v[i]);
    recvBit(ack);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      v[i] = b;
    end
    sendBit(nack);
  endtask

  task automatic sendAddr(input logic [7:0] a, input logic expAck);
    logic ack;
    startCond();
    writeByte(a, ack);
    checkOutput("addr_ack_bit", ack, expAck ? 0 : 1);
    checkOutput("busy_after_addr", busy_o, expAck);
  endtask

  task automatic writePtr(input logic [7:0] p);
    logic ack;
    writeByte(p, ack);
    checkOutput("ptr_ack_bit", ack, 0);
    ptrM = p % 16;
  endtask

  task automatic writeData(input logic [7:0] d);
    logic ack;
    wr_t  e;
    e.a = 4'(ptrM);
    e.d = d;
    expQ.push_back(e);
    writeByte(d, ack);
    checkOutput("data_ack_bit", ack, 0);
    ptrM = (ptrM + 1) % 16;
  endtask

  task automatic readData(input logic nack, output logic [7:0] v);
    logic [7:0] exp;
    exp = model[ptrM];
    readByte(nack, v);
    checkOutput("read_data", v, exp);
    ptrM = (ptrM + 1) % 16;
    if (nack) begin
      waitClk(4);
      checkOutput("busy_after_nack", busy_o, 0);
    end
  endtask

  task automatic endStop();
    stopCond();
    waitClk(4);
    checkOutput("busy_after_stop", busy_o, 0);
    checkOutput("pending_wr_stb", expQ.size(), 0);
  endtask

  task automatic applyStimulus(input int kind);
    logic [7:0] v, a;
    logic       ack;
    int         n, k;
    n = $urandom_range(1, 4);
    case (kind)
      0: begin
        sendAddr(8'h84, 1'b1);
        writePtr(8'($urandom_range(0, 255)));
        for (int j = 0; j < n; j++) writeData(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(1, 6);
          for (int j = 0; j < k; j++) sendBit(1'($urandom_range(0, 1)));
          if ($urandom_range(0, 1) == 1) begin
            sendAddr(8'h85, 1'b1);
            readData(1'b1, v);
          end
        end
        endStop();
      end
      1: begin
        sendAddr(8'h85, 1'b1);
        for (int j = 0; j < n; j++) readData(j == n - 1, v);
        endStop();
      end
      2: begin
        sendAddr(8'h84, 1'b1);
        writePtr(8'($urandom_range(0, 255)));
        sendAddr(8'h85, 1'b1);
        for (int j = 0; j < n; j++) readData(j == n - 1, v);
        endStop();
      end
      default: begin
        a = 8'($urandom_range(0, 255));
        if (a[7:1] == 7'h42) a = a ^ 8'h10;
        sendAddr(a, 1'b0);
        writeByte(8'($urandom_range(0, 255)), ack);
        checkOutput("ignored_byte_ack", ack, 1);
        endStop();
      end
    endcase
  endtask

  task automatic peekReg(input logic [3:0] idx, input logic [7:0] exp, input string name);
    holdHost = 1'b1;
    host_addr = idx;
    waitClk(1);
    checkOutput(name, host_rdata, exp);
    holdHost = 1'b0;
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    logic [7:0] v;
    logic       ack;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    waitClk(4);
    checkOutput("reset_sda_low", sda_low_o, 0);
    checkOutput("reset_scl_low", scl_low_o, 0);
    checkOutput("reset_wr_stb", wr_stb_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_wr_addr", wr_addr_o, 0);
    checkOutput("reset_wr_data", wr_data_o, 0);
    checkOutput("reset_host_rdata", host_rdata, 0);
    rst = 1'b0;
    holdHost = 1'b0;
    waitClk(4);

    $display("[TB] directed: write 0x84 ptr 3 data A5 5A");
    sendAddr(8'h84, 1'b1); writePtr(8'h03); writeData(8'hA5); writeData(8'h5A); endStop();
    peekReg(4'd3, 8'hA5, "lit_reg3");
    peekReg(4'd4, 8'h5A, "lit_reg4");

    $display("[TB] directed: pointer then repeated START read");
    sendAddr(8'h84, 1'b1); writePtr(8'h03); sendAddr(8'h85, 1'b1);
    readData(1'b0, v); checkOutput("lit_rd_a5", v, 8'hA5);
    readData(1'b1, v); checkOutput("lit_rd_5a", v, 8'h5A);
    endStop();
    sendAddr(8'h85, 1'b1); readData(1'b1, v); checkOutput("lit_ptr5_rd", v, 8'h00); endStop();

    $display("[TB] directed: foreign address 0x90");
    sendAddr(8'h90, 1'b0);
    writeByte(8'h55, ack);
    checkOutput("foreign_byte_ack", ack, 1);
    endStop();

    $display("[TB] directed: pointer wrap");
    sendAddr(8'h84, 1'b1); writePtr(8'h0F); writeData(8'h11); writeData(8'h22); endStop();
    peekReg(4'd15, 8'h11, "lit_reg15");
    peekReg(4'd0, 8'h22, "lit_reg0");
    sendAddr(8'h85, 1'b1); readData(1'b1, v); checkOutput("lit_ptr1_rd", v, 8'h00); endStop();

    $display("[TB] directed: reset inside a data byte");
    sendAddr(8'h84, 1'b1); writePtr(8'h02);
    for (int j = 0; j < 4; j++) sendBit(1'b1);
    checkOutput("pre_reset_busy", busy_o, 1);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    ptrM = 0;
    expQ.delete();
    #1;
    checkOutput("rst_sda_low", sda_low_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    holdHost = 1'b1;
    host_addr = 4'd3;
    #1;
    checkOutput("rst_reg3_cleared", host_rdata, 8'h00);
    scl_m = 1'b1;
    sda_m = 1'b1;
    waitClk(4);
    rst = 1'b0;
    holdHost = 1'b0;
    waitClk(4);
    sendAddr(8'h84, 1'b1); writePtr(8'h07); writeData(8'h3C); endStop();
    sendAddr(8'h84, 1'b1); writePtr(8'h07); sendAddr(8'h85, 1'b1);
    readData(1'b1, v); checkOutput("lit_after_reset_rd", v, 8'h3C);
    endStop();

    $display("[TB] random transactions");
    for (int t = 0; t < 20; t++) applyStimulus($urandom_range(0, 3));

    waitClk(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
